// File: rtl/iir_biquad_cascade_tdm.sv
// Cascade of direct-form-II-transposed biquads sharing one multiplier,
// five products per section, one sample in flight at a time.
module iir_biquad_cascade_tdm #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_STAGES  = 4,
    parameter int FRAC_BITS   = 14
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic signed [DATA_WIDTH-1:0]        s_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic signed [DATA_WIDTH-1:0]        m_data,
    input  logic                                coef_we,
    input  logic [$clog2(5*NUM_STAGES)-1:0]     coef_addr,
    input  logic signed [COEFF_WIDTH-1:0]       coef_wdata,
    input  logic                                state_clr,
    output logic                                busy,
    output logic                                sat_flag,
    output logic                                coef_err
);

    localparam int NCOEF = 5 * NUM_STAGES;
    localparam int AW    = $clog2(NCOEF);
    localparam int SW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int PW    = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W = PW + 2;

    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
    localparam logic signed [COEFF_WIDTH-1:0] B0_UNITY = COEFF_WIDTH'(1 << FRAC_BITS);
    localparam logic [AW-1:0] LAST_SLOT = AW'(NCOEF - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

    state_t                          state_q;
    logic [AW-1:0]                   cnt_q;
    logic [2:0]                      k_q;
    logic [SW-1:0]                   stage_q;
    logic                            m_valid_q;
    logic signed [DATA_WIDTH-1:0]    m_data_q;
    logic                            coef_err_q;
    logic                            sat_q;
    logic signed [DATA_WIDTH-1:0]    x_q;
    logic signed [DATA_WIDTH-1:0]    y_q;
    logic signed [COEFF_WIDTH-1:0]   coef_q [NCOEF];
    logic signed [ACC_W-1:0]         s1_q [NUM_STAGES];
    logic signed [ACC_W-1:0]         s2_q [NUM_STAGES];

    logic                            addr_ok;
    logic signed [COEFF_WIDTH-1:0]   mul_a;
    logic signed [DATA_WIDTH-1:0]    mul_b;
    logic signed [PW-1:0]            prod;
    logic signed [ACC_W-1:0]         prod_ext;
    logic signed [ACC_W-1:0]         s1_cur;
    logic signed [ACC_W-1:0]         s2_cur;
    logic signed [ACC_W-1:0]         acc_sh;
    logic signed [DATA_WIDTH-1:0]    y_d;
    logic                            y_ovf_d;

    assign addr_ok  = (int'(coef_addr) < NCOEF);
    assign s_ready  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign sat_flag = sat_q;
    assign coef_err = coef_err_q;

    // The coefficient index equals the slot counter: slot k of stage s is s*5+k.
    assign mul_a    = coef_q[cnt_q];
    assign mul_b    = (k_q < 3'd3) ? x_q : y_q;
    assign prod     = PW'(mul_a) * PW'(mul_b);
    assign prod_ext = ACC_W'(prod);
    assign s1_cur   = s1_q[stage_q];
    assign s2_cur   = s2_q[stage_q];
    assign acc_sh   = (prod_ext + s1_cur) >>> FRAC_BITS;

    // NOTE: every output of a combinational block is assigned on all paths
    // (defaults first) so no latch is inferred.
    always_comb begin
        y_d     = DATA_WIDTH'(acc_sh);
        y_ovf_d = 1'b0;
        if (acc_sh > Y_MAX) begin
            y_d     = DATA_WIDTH'(Y_MAX);
            y_ovf_d = 1'b1;
        end else if (acc_sh < Y_MIN) begin
            y_d     = DATA_WIDTH'(Y_MIN);
            y_ovf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            stage_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            coef_err_q <= 1'b0;
        end else begin
            coef_err_q <= coef_we && ((state_q != IDLE) || !addr_ok);
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        state_q <= COMPUTE;
                        cnt_q   <= '0;
                        k_q     <= '0;
                        stage_q <= '0;
                    end
                end
                COMPUTE: begin
                    if (cnt_q == LAST_SLOT) begin
                        state_q <= OUTPUT;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                        if (k_q == 3'd4) begin
                            k_q     <= '0;
                            stage_q <= stage_q + SW'(1);
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                OUTPUT: begin
                    // First OUTPUT cycle registers the result; handshake follows.
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= y_q;
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: coefficient storage is reset because its reset contents define
    // the pass-through behaviour, which rules out mapping it to a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                coef_q[i] <= (i % 5 == 0) ? B0_UNITY : '0;
            end
        end else if (coef_we && (state_q == IDLE) && addr_ok) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_clr) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            s1_q[i] <= '0;
                            s2_q[i] <= '0;
                        end
                    end
                    if (s_valid) begin
                        x_q <= s_data;
                    end
                end
                COMPUTE: begin
                    // s1 and s2 are read before being overwritten within a section.
                    case (k_q)
                        3'd0: begin
                            y_q <= y_d;
                            if (y_ovf_d) begin
                                sat_q <= 1'b1;
                            end
                        end
                        3'd1: s1_q[stage_q] <= prod_ext + s2_cur;
                        3'd2: s2_q[stage_q] <= prod_ext;
                        3'd3: s1_q[stage_q] <= s1_cur - prod_ext;
                        default: begin
                            s2_q[stage_q] <= s2_cur - prod_ext;
                            x_q           <= y_q;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade_tdm.sv
// Self-checking bench: directed cases plus randomized samples compared
// against a plain-arithmetic model of the biquad cascade.
module tb_iir_biquad_cascade_tdm;

    localparam int NS  = 4;
    localparam int NC  = 5 * NS;
    localparam int F   = 14;
    localparam int LAT = 5 * NS + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic signed [15:0] m_data;
    logic               coef_we = 1'b0;
    logic [4:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               state_clr = 1'b0;
    logic               busy;
    logic               sat_flag;
    logic               coef_err;

    int n_tests = 0;
    int n_fail  = 0;

    longint mc [NC];
    longint ms1 [NS];
    longint ms2 [NS];
    bit     msat;

    iir_biquad_cascade_tdm dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .state_clr  (state_clr),
        .busy       (busy),
        .sat_flag   (sat_flag),
        .coef_err   (coef_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) begin
            ms1[i] = 0;
            ms2[i] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) mc[i] = (i % 5 == 0) ? (64'sd1 <<< F) : 0;
        model_clear();
        msat = 1'b0;
    endfunction

    // y = b0*x + s1; s1' = b1*x - a1*y + s2; s2' = b2*x - a2*y, y floored and saturated.
    function automatic int model_step(input int x);
        longint v = x;
        longint y;
        for (int st = 0; st < NS; st++) begin
            y = (mc[st*5] * v + ms1[st]) >>> F;
            if (y > 32767) begin
                y = 32767;
                msat = 1'b1;
            end else if (y < -32768) begin
                y = -32768;
                msat = 1'b1;
            end
            ms1[st] = mc[st*5+1] * v - mc[st*5+3] * y + ms2[st];
            ms2[st] = mc[st*5+2] * v - mc[st*5+4] * y;
            v = y;
        end
        return int'(v);
    endfunction

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!s_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rdy"}, s_ready, 1);
    endtask

    task automatic write_coef(input int addr, input int val);
        wait_idle("wr");
        coef_we = 1'b1;
        coef_addr = 5'(addr);
        coef_wdata = 16'(val);
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        mc[addr] = val;
        check("wr_err", coef_err, 0);
    endtask

    task automatic pulse_clr();
        wait_idle("clr");
        state_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        state_clr = 1'b0;
        model_clear();
    endtask

    task automatic run_sample(input int x, input bit clr, input bit we, input int waddr,
                              input int wdata, input string tag, output int got);
        int exp_y;
        int k;
        wait_idle(tag);
        if (clr) model_clear();
        if (we) mc[waddr] = wdata;
        exp_y = model_step(x);
        s_valid = 1'b1;
        s_data = 16'(x);
        state_clr = clr;
        coef_we = we;
        coef_addr = 5'(waddr);
        coef_wdata = 16'(wdata);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        state_clr = 1'b0;
        coef_we = 1'b0;
        if (we) check({tag, "_err"}, coef_err, 0);
        k = 0;
        while (!m_valid && k < 60) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check({tag, "_lat"}, k, LAT);
        got = m_data;
        check({tag, "_y"}, got, exp_y);
        check({tag, "_sat"}, sat_flag, msat);
    endtask

    task automatic release_out();
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic send(input int x, input string tag, output int got);
        run_sample(x, 1'b0, 1'b0, 0, 0, tag, got);
        release_out();
    endtask

    initial begin
        int y;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 1);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_cerr", coef_err, 0);
        rst = 1'b1;
        @(negedge clk);

        send(1000, "pass", y);
        check("pass_lit", y, 1000);

        write_coef(0, 8192);
        send(1000, "half", y);
        check("half_lit", y, 500);
        send(-1, "floor", y);
        check("floor_lit", y, -1);

        write_coef(0, 16384);
        write_coef(3, -8192);
        send(1600, "imp0", y);
        check("imp0_lit", y, 1600);
        send(0, "imp1", y);
        check("imp1_lit", y, 800);
        send(0, "imp2", y);
        check("imp2_lit", y, 400);
        send(0, "imp3", y);
        check("imp3_lit", y, 200);
        pulse_clr();
        send(0, "clr", y);
        check("clr_lit", y, 0);

        write_coef(3, 0);
        write_coef(0, 32767);
        send(30000, "satp", y);
        check("satp_lit", y, 32767);
        check("satp_flag", sat_flag, 1);
        send(-30000, "satn", y);
        check("satn_lit", y, -32768);

        write_coef(0, 16384);
        run_sample(123, 1'b0, 1'b0, 0, 0, "hold", y);
        s_valid = 1'b1;
        s_data = 16'sd777;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                coef_we = 1'b1;
                coef_addr = 5'd0;
                coef_wdata = 16'sd1234;
            end
            @(posedge clk);
            @(negedge clk);
            coef_we = 1'b0;
            check("hold_data", m_data, 123);
            check("hold_valid", m_valid, 1);
            check("hold_rdy", s_ready, 0);
            if (i == 3) check("hold_cerr1", coef_err, 1);
            if (i == 4) check("hold_cerr0", coef_err, 0);
        end
        s_valid = 1'b0;
        release_out();
        check("hold_idle", busy, 0);
        send(200, "after_hold", y);
        check("after_hold_lit", y, 200);

        wait_idle("badaddr");
        coef_we = 1'b1;
        coef_addr = 5'd25;
        coef_wdata = 16'sd77;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        check("bad_cerr1", coef_err, 1);
        @(posedge clk);
        @(negedge clk);
        check("bad_cerr0", coef_err, 0);

        for (int a = 0; a < NC; a++) write_coef(a, int'($urandom_range(0, 8192)) - 4096);
        for (int n = 0; n < 30; n++) begin
            bit clr = ($urandom_range(0, 7) == 0);
            bit we  = ($urandom_range(0, 3) == 0);
            int wa  = int'($urandom_range(0, NC - 1));
            int wd  = int'($urandom_range(0, 8192)) - 4096;
            int x   = int'($urandom_range(0, 40000)) - 20000;
            run_sample(x, clr, we, wa, wd, "rnd", y);
            release_out();
        end

        wait_idle("midrst");
        s_valid = 1'b1;
        s_data = 16'sd555;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("mrst_ready", s_ready, 1);
        check("mrst_mvalid", m_valid, 0);
        check("mrst_mdata", m_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_sat", sat_flag, 0);
        check("mrst_cerr", coef_err, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        send(1000, "mrst_pass", y);
        check("mrst_pass_lit", y, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
